// File: rtl/rtc_pkg.sv
// Shared constants and BCD helpers for the real-time clock display.
// Used by rtc_display; the optional alarm is enabled with RTC_DISPLAY_ALARM_EN.
package rtc_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [7:0] MAX_SEC  = 8'h59;
   localparam logic [7:0] MAX_MIN  = 8'h59;
   localparam logic [4:0] MAX_HOUR = 5'd23;

   // Two-digit BCD increment that wraps to 00 after max_v.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      logic [7:0] r;
      if (v == max_v) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [4:0] display_hour(input logic [4:0] h, input logic mode_12h);
      logic [4:0] r;
      if (!mode_12h) begin
         r = h;
      end else if (h == 5'd0) begin
         r = 5'd12;
      end else if (h > 5'd12) begin
         r = h - 5'd12;
      end else begin
         r = h;
      end
      return r;
   endfunction

   // Binary 0..23 to two BCD digits by range compare, avoiding a divider.
   function automatic logic [7:0] hour_to_bcd(input logic [4:0] h);
      logic [7:0] r;
      if (h >= 5'd20) begin
         r = 8'h20 + {3'b000, h - 5'd20};
      end else if (h >= 5'd10) begin
         r = 8'h10 + {3'b000, h - 5'd10};
      end else begin
         r = {3'b000, h};
      end
      return r;
   endfunction

endpackage

// File: rtl/rtc_display_seg7.sv
// seg7_encode: combinational BCD digit to seven-segment code (bit6 = a .. bit0 = g).
// Codes are stored active-low; SEG_ACTIVE_LOW = 0 inverts the output.
module seg7_encode
   import rtc_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   logic [6:0] w_raw;

   // Digit lookup; out-of-range codes show nothing.
   always_comb begin
      w_raw = SEG_BLANK;
      if (i_blank) begin
         w_raw = SEG_BLANK;
      end else begin
         case (i_bcd)
            4'd0:    w_raw = SEG_0;
            4'd1:    w_raw = SEG_1;
            4'd2:    w_raw = SEG_2;
            4'd3:    w_raw = SEG_3;
            4'd4:    w_raw = SEG_4;
            4'd5:    w_raw = SEG_5;
            4'd6:    w_raw = SEG_6;
            4'd7:    w_raw = SEG_7;
            4'd8:    w_raw = SEG_8;
            4'd9:    w_raw = SEG_9;
            default: w_raw = SEG_BLANK;
         endcase
      end
   end

   assign o_seg = (SEG_ACTIVE_LOW != 0) ? w_raw : ~w_raw;

endmodule

// File: rtl/rtc_display.sv
// Real-time clock with set mode and six registered seven-segment digit outputs.
// Define RTC_DISPLAY_ALARM_EN to add the alarm compare inputs and o_alarm_hit pulse.
module rtc_display
   import rtc_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_mode_12h,
   input  logic       i_set_en,
   input  logic       i_inc_hour,
   input  logic       i_inc_min,
`ifdef RTC_DISPLAY_ALARM_EN
   input  logic [4:0] i_alarm_hour,
   input  logic [6:0] i_alarm_min,
   output logic       o_alarm_hit,
`endif
   output logic [6:0] o_led_a,
   output logic [6:0] o_led_b,
   output logic [6:0] o_led_c,
   output logic [6:0] o_led_d,
   output logic [6:0] o_led_e,
   output logic [6:0] o_led_f,
   output logic       o_pm,
   output logic       o_sec_tick
);

   localparam int             PW        = $clog2(CLK_HZ);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [6:0]     LED_ZERO  = (SEG_ACTIVE_LOW != 0) ? SEG_0 : ~SEG_0;

   logic [PW-1:0] r_presc;
   logic [7:0]    r_sec;
   logic [7:0]    r_min;
   logic [4:0]    r_hour;
   logic          r_inc_hour_d;
   logic          r_inc_min_d;
   logic          r_sec_tick;
   logic [6:0]    r_led_a, r_led_b, r_led_c, r_led_d, r_led_e, r_led_f;
   logic          r_pm;

   logic [PW-1:0] w_presc_nxt;
   logic [7:0]    w_sec_nxt;
   logic [7:0]    w_min_nxt;
   logic [4:0]    w_hour_nxt;
   logic          w_tick;
   logic          w_hour_edge;
   logic          w_min_edge;
   logic [7:0]    w_hour_bcd;
   logic          w_blank_tens;
   logic [6:0]    w_seg_a, w_seg_b, w_seg_c, w_seg_d, w_seg_e, w_seg_f;

   // Next-state for prescaler and time; set mode freezes seconds and edits hh:mm without carry.
   always_comb begin
      w_tick      = (r_presc == PRESC_MAX) & ~i_set_en;
      w_hour_edge = i_set_en & i_inc_hour & ~r_inc_hour_d;
      w_min_edge  = i_set_en & i_inc_min & ~r_inc_min_d;
      w_presc_nxt = r_presc + PW'(1);
      w_sec_nxt   = r_sec;
      w_min_nxt   = r_min;
      w_hour_nxt  = r_hour;
      if (i_set_en) begin
         w_presc_nxt = '0;
         w_sec_nxt   = 8'h00;
         if (w_min_edge) begin
            w_min_nxt = bcd_inc(r_min, MAX_MIN);
         end else begin
            w_min_nxt = r_min;
         end
         if (w_hour_edge) begin
            w_hour_nxt = (r_hour == MAX_HOUR) ? 5'd0 : r_hour + 5'd1;
         end else begin
            w_hour_nxt = r_hour;
         end
      end else if (w_tick) begin
         w_presc_nxt = '0;
         w_sec_nxt   = bcd_inc(r_sec, MAX_SEC);
         if (r_sec == MAX_SEC) begin
            w_min_nxt = bcd_inc(r_min, MAX_MIN);
            if (r_min == MAX_MIN) begin
               w_hour_nxt = (r_hour == MAX_HOUR) ? 5'd0 : r_hour + 5'd1;
            end else begin
               w_hour_nxt = r_hour;
            end
         end else begin
            w_min_nxt = r_min;
         end
      end else begin
         w_presc_nxt = r_presc + PW'(1);
      end
   end

   // Time, prescaler, edge-detect copies and the second pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc      <= '0;
         r_sec        <= 8'h00;
         r_min        <= 8'h00;
         r_hour       <= 5'd0;
         r_inc_hour_d <= 1'b0;
         r_inc_min_d  <= 1'b0;
         r_sec_tick   <= 1'b0;
      end else begin
         r_presc      <= w_presc_nxt;
         r_sec        <= w_sec_nxt;
         r_min        <= w_min_nxt;
         r_hour       <= w_hour_nxt;
         r_inc_hour_d <= i_inc_hour;
         r_inc_min_d  <= i_inc_min;
         r_sec_tick   <= w_tick;
      end
   end

   assign w_hour_bcd   = hour_to_bcd(display_hour(r_hour, i_mode_12h));
   assign w_blank_tens = i_mode_12h & (w_hour_bcd[7:4] == 4'd0);

   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_a (.i_bcd(r_sec[3:0]),      .i_blank(1'b0),         .o_seg(w_seg_a));
   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_b (.i_bcd(r_sec[7:4]),      .i_blank(1'b0),         .o_seg(w_seg_b));
   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_c (.i_bcd(r_min[3:0]),      .i_blank(1'b0),         .o_seg(w_seg_c));
   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_d (.i_bcd(r_min[7:4]),      .i_blank(1'b0),         .o_seg(w_seg_d));
   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_e (.i_bcd(w_hour_bcd[3:0]), .i_blank(1'b0),         .o_seg(w_seg_e));
   seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_f (.i_bcd(w_hour_bcd[7:4]), .i_blank(w_blank_tens), .o_seg(w_seg_f));

   // Display registers, one cycle behind the time state and mode.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_led_a <= LED_ZERO;
         r_led_b <= LED_ZERO;
         r_led_c <= LED_ZERO;
         r_led_d <= LED_ZERO;
         r_led_e <= LED_ZERO;
         r_led_f <= LED_ZERO;
         r_pm    <= 1'b0;
      end else begin
         r_led_a <= w_seg_a;
         r_led_b <= w_seg_b;
         r_led_c <= w_seg_c;
         r_led_d <= w_seg_d;
         r_led_e <= w_seg_e;
         r_led_f <= w_seg_f;
         r_pm    <= i_mode_12h & (r_hour >= 5'd12);
      end
   end

`ifdef RTC_DISPLAY_ALARM_EN
   logic r_alarm_hit;

   // Only a counted second landing on hh:mm:00 fires; set-mode edits never raise r_sec_tick.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_alarm_hit <= 1'b0;
      end else begin
         r_alarm_hit <= r_sec_tick & (r_sec == 8'h00) & (r_min == {1'b0, i_alarm_min})
                        & (r_hour == i_alarm_hour);
      end
   end

   assign o_alarm_hit = r_alarm_hit;
`endif

   assign o_led_a    = r_led_a;
   assign o_led_b    = r_led_b;
   assign o_led_c    = r_led_c;
   assign o_led_d    = r_led_d;
   assign o_led_e    = r_led_e;
   assign o_led_f    = r_led_f;
   assign o_pm       = r_pm;
   assign o_sec_tick = r_sec_tick;

endmodule

// File: doc/rtc_display.md
RTC_DISPLAY -- requirements
Module: rtc_display

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clk cycles per second; legal range >= 2.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1; 1 means a segment is lit by 0, 0 inverts all segment outputs.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 mode_12h  input  1  1 selects 12-hour display, 0 selects 24-hour.
REQ-006 set_en  input  1  1 selects time-set mode.
REQ-007 inc_hour  input  1  level input; each rising edge increments the hour in set mode.
REQ-008 inc_min  input  1  level input; each rising edge increments the minute in set mode.
REQ-009 led_a..led_f  output  7 each  segment codes for seconds ones, seconds tens, minutes ones, minutes tens, hours ones and hours tens, in that order; bit6 = seg a ... bit0 = seg g.
REQ-010 pm  output  1  1 when mode_12h = 1 and hour >= 12.
REQ-011 sec_tick  output  1  one-cycle pulse on each counted second.

Function
REQ-012 Prescaler runs 0..CLK_HZ-1 with width $clog2(CLK_HZ); sec_tick is asserted in the cycle the prescaler wraps, giving exactly one pulse per CLK_HZ cycles.
REQ-013 Time is held as BCD seconds (0-59) and minutes (0-59) plus a binary hour (0-23); no division or modulo operators are used.
REQ-014 On sec_tick with set_en = 0: seconds increment; 59 -> 00 carries to minutes; minute 59 -> 00 carries to hour; hour 23 -> 0.
REQ-015 The roll from 23:59:59 to 00:00:00 happens in a single cycle.
REQ-016 set_en = 1 holds the prescaler at 0, holds seconds at 00, and suppresses sec_tick.
REQ-017 inc_hour and inc_min are edge-detected against a registered copy; a held level gives exactly one increment.
REQ-018 Increments wrap with no carry: minute 59 -> 00, hour 23 -> 0.
REQ-019 inc_hour and inc_min edges in the same cycle both apply.
REQ-020 inc_hour and inc_min are ignored when set_en = 0.
REQ-021 When set_en falls, the prescaler restarts from 0; the first sec_tick comes CLK_HZ cycles later.
REQ-022 12-hour display mapping: hour 0 -> 12, 13..23 -> 1..11, 1..12 unchanged; the hours-tens digit is blanked (all segments off) when it is 0.
REQ-023 24-hour display shows 00..23 with no blanking.
REQ-024 mode_12h affects only the display; the internal hour is unchanged.
REQ-025 Segment codes for digits 0-9, active-low: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-026 led_* and pm are registered: they reflect the time state with 1 cycle latency after any state or mode change.

Reset
REQ-027 reset = 1 at a clk edge clears the prescaler, time (00:00:00), the edge-detect registers and sec_tick.
REQ-028 During reset, all led_* are driven to the code for digit 0 and pm = 0.
REQ-029 reset dominates set_en, the increment inputs and any pending tick, including a reset asserted mid-set.

Configuration
REQ-030 Macro RTC_DISPLAY_ALARM_EN, when defined, adds inputs alarm_hour [4:0] (binary, 0-23) and alarm_min [6:0] (BCD) and output alarm_hit.
REQ-031 alarm_hit is a one-cycle pulse, registered, in the cycle after time becomes alarm_hour:alarm_min:00 via a sec_tick.
REQ-032 alarm_hit does not fire from set-mode edits; it resets to 0.
REQ-033 Without RTC_DISPLAY_ALARM_EN, those ports and their logic are absent and all other behaviour is identical.

Structure
REQ-034 Package rtc_pkg holds the ten digit segment constants, SEG_BLANK, MAX_SEC, MAX_MIN and MAX_HOUR.
REQ-035 Sub-module seg7_encode (combinational, 4-bit BCD in, blank flag in, 7-bit out) is instantiated six times.

Verification
REQ-036 Reset, CLK_HZ = 4 -> all led_* = 0000001, pm = 0, sec_tick = 0 for the cycle after reset.
REQ-037 CLK_HZ = 4, release reset -> sec_tick on cycle 4; led_a = 1001111 one cycle later.
REQ-038 set_en = 1, 23 inc_hour pulses, 59 inc_min pulses, set_en = 0, 60 ticks -> 23:59:00 advances to 00:00:00 in one cycle after the 60th tick.
REQ-039 mode_12h = 1, hour 13 -> led_f = 1111111, led_e = 1001111, pm = 1; hour 0 -> led_f = 1001111, led_e = 0010010, pm = 0.
REQ-040 set_en = 1 with inc_min held high 10 cycles -> minute = 01 only; same stimulus with set_en = 0 -> no change.
REQ-041 RTC_DISPLAY_ALARM_EN defined, alarm 00:01 -> alarm_hit high for exactly one cycle after the 60th tick, and no pulse when minute 01 is reached by set edits.
